alu_multicycle: RTL
===================

Name: alu_multicycle

Overview:
- Parametrised successor to the single-cycle execute-stage ALU.
- Keeps the ADD/SUB/MUL encodings and the op2-ignore behaviour. Adds AND, OR, SLT, unsigned DIV and REM.
- MUL and DIV run iteratively over several cycles, behind a valid/ready handshake, so the exec stage stalls on `busy` instead of inferring a combinational multiplier.
- Sits between the decode/exec pipeline register and the exec/mem register.

Parameters:
- WIDTH, 32, operand and result width in bits (≥4).
- CTRL_W, 3, width of aluCtrl.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request present.
- in_ready  output  1  block can accept a request this cycle.
- op1  input  WIDTH  first operand.
- op2  input  WIDTH  second operand.
- ignore_op2  input  1  when 1, op2 is treated as 0 for every op.
- aluCtrl  input  CTRL_W  operation select.
- out_valid  output  1  result and zero are valid.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  registered result.
- zero  output  1  registered (op1 == op2), compared on raw op2 regardless of ignore_op2.
- busy  output  1  1 whenever state != IDLE.

Behaviour:
- Op encodings (aluCtrl):
  - 000 ADD
  - 010 SUB
  - 001 MUL (low WIDTH bits of unsigned product)
  - 011 DIV (unsigned quotient)
  - 100 REM (unsigned remainder)
  - 101 AND
  - 110 OR
  - 111 SLT (signed op1 < op2 → 1, else 0)
- Arithmetic is modulo 2^WIDTH; no overflow flag.
- Effective op2: e2 = ignore_op2 ? 0 : op2, latched at accept.
- Accept: a request is taken when in_valid && in_ready. Operands, e2, aluCtrl and zero are latched on that edge.
- States:
  - IDLE: in_ready=1. On accept, go to EXEC1 for single-cycle ops, or ITER for MUL/DIV/REM.
  - EXEC1: compute the result, go to DONE. Latency from accept to out_valid is 2 cycles.
  - ITER: one step per cycle, counter runs from WIDTH-1 down to 0.
    - MUL uses shift-add. DIV/REM use restoring division.
    - When the counter reaches 0, go to DONE. Latency from accept to out_valid is WIDTH+1 cycles.
  - DONE: out_valid=1; result and zero are held stable. If out_ready, go to IDLE.
- in_ready is 1 only in IDLE. There is no overlap of operations; throughput is at most one op per 3 cycles.
- Divide by zero (e2 == 0):
  - DIV → all ones. REM → op1.
  - Still takes WIDTH+1 cycles, for fixed latency.
- MUL with e2 == 0, including ignore_op2=1: result 0, full iteration latency.
- An undefined aluCtrl cannot occur with CTRL_W=3. If CTRL_W > 3, upper codes produce result 0 via EXEC1.
- in_valid outside IDLE is ignored; the request is not latched.
- out_ready while not in DONE has no effect.
- Reset (synchronous, any state, including mid-ITER):
  - state=IDLE, result=0, zero=0, out_valid=0, busy=0, iteration counter=0, internal accumulators=0.
  - In-flight op is discarded. in_ready=1 on the first cycle after reset deasserts.
- Reset and in_valid asserted in the same cycle: reset wins; no accept.

Test Plan:
- ADD 5+7, ignore_op2=0, out_ready=1 → out_valid 2 cycles after accept, result=12, zero=0. Next cycle in_ready=1.
- SUB 9−9 → result=0, zero=1. SUB 3, op2=10, ignore_op2=1 → result=3, zero=0.
- MUL 0x0001_0000 × 0x0001_0003, WIDTH=32 → result=0x0003_0000 exactly 33 cycles after accept. busy=1 throughout, in_ready=0 throughout.
- DIV 100/7 → 14; REM 100/7 → 2; DIV 100/0 → 0xFFFF_FFFF; REM 100/0 → 100. Each takes 33 cycles.
- Backpressure: ADD 1+1 with out_ready=0 for 5 cycles → result=2 held, out_valid held. Second in_valid during this is ignored. out_ready=1 → IDLE next cycle.
- Reset at iteration 10 of a MUL → next cycle out_valid=0, result=0, busy=0. A following ADD 2+2 → result=4.

Source files
------------

// File: rtl/alu_multicycle.sv
// Execute-stage ALU with valid/ready handshake; MUL/DIV/REM iterate one bit per cycle
// (shift-add and restoring division), all other ops complete in a single EXEC1 cycle.
module alu_multicycle #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  op1,
  input  logic [WIDTH-1:0]  op2,
  input  logic              ignore_op2,
  input  logic [CTRL_W-1:0] aluCtrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic              zero,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EXEC1 = 2'd1;
  localparam logic [1:0] ITER  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [CTRL_W-1:0] OP_ADD = CTRL_W'(3'b000);
  localparam logic [CTRL_W-1:0] OP_MUL = CTRL_W'(3'b001);
  localparam logic [CTRL_W-1:0] OP_SUB = CTRL_W'(3'b010);
  localparam logic [CTRL_W-1:0] OP_DIV = CTRL_W'(3'b011);
  localparam logic [CTRL_W-1:0] OP_REM = CTRL_W'(3'b100);
  localparam logic [CTRL_W-1:0] OP_AND = CTRL_W'(3'b101);
  localparam logic [CTRL_W-1:0] OP_OR  = CTRL_W'(3'b110);
  localparam logic [CTRL_W-1:0] OP_SLT = CTRL_W'(3'b111);

  logic [1:0]        r_state;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [CTRL_W-1:0] r_op;
  logic [WIDTH-1:0]  r_hi;
  logic [WIDTH-1:0]  r_lo;
  logic [CNT_W-1:0]  r_cnt;
  logic [WIDTH-1:0]  r_result;
  logic              r_zero;

  logic              w_accept;
  logic              w_iter_op;
  logic [WIDTH-1:0]  w_e2;
  logic [WIDTH-1:0]  w_exec_res;
  logic [WIDTH-1:0]  w_mul_acc;
  logic [WIDTH:0]    w_div_shift;
  logic [WIDTH:0]    w_div_diff;
  logic              w_div_ge;
  logic [WIDTH-1:0]  w_rem_next;
  logic [WIDTH-1:0]  w_quo_next;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign result    = r_result;
  assign zero      = r_zero;

  assign w_accept  = in_valid && (r_state == IDLE);
  assign w_iter_op = (aluCtrl == OP_MUL) || (aluCtrl == OP_DIV) || (aluCtrl == OP_REM);
  assign w_e2      = ignore_op2 ? '0 : op2;

  // MUL: r_hi accumulates, r_a is the left-shifting multiplicand, r_lo the multiplier.
  assign w_mul_acc = r_lo[0] ? (r_hi + r_a) : r_hi;

  // DIV/REM: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
  // A zero divisor always subtracts, giving an all-ones quotient and remainder = op1.
  assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_b};
  assign w_div_ge    = ~w_div_diff[WIDTH];
  assign w_rem_next  = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
  assign w_quo_next  = {r_lo[WIDTH-2:0], w_div_ge};

  always_comb begin
    w_exec_res = '0;
    case (r_op)
      OP_ADD:  w_exec_res = r_a + r_b;
      OP_SUB:  w_exec_res = r_a - r_b;
      OP_AND:  w_exec_res = r_a & r_b;
      OP_OR:   w_exec_res = r_a | r_b;
      OP_SLT:  w_exec_res = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      default: w_exec_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a    <= op1;
            r_b    <= w_e2;
            r_op   <= aluCtrl;
            r_zero <= (op1 == op2);
            r_cnt  <= CNT_W'(WIDTH - 1);
            r_hi   <= '0;
            r_lo   <= (aluCtrl == OP_MUL) ? w_e2 : op1;
            r_state <= w_iter_op ? ITER : EXEC1;
          end
        end
        EXEC1: begin
          r_result <= w_exec_res;
          r_state  <= DONE;
        end
        ITER: begin
          if (r_op == OP_MUL) begin
            r_hi <= w_mul_acc;
            r_a  <= r_a << 1;
            r_lo <= r_lo >> 1;
          end else begin
            r_hi <= w_rem_next;
            r_lo <= w_quo_next;
          end
          if (r_cnt == '0) begin
            if (r_op == OP_MUL)      r_result <= w_mul_acc;
            else if (r_op == OP_DIV) r_result <= w_quo_next;
            else                     r_result <= w_rem_next;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
